// File: rtl/sr_latch_write_arbiter_pkg.sv
// Shared types and constants for the SR latch write arbiter.
// Used by the top, its round-robin sub-module and the requester interface.
package sr_latch_write_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CHECK = 3'd4
  } state_e;

  localparam int PHASE_CNT_W = 8;

  typedef logic req_id_t;

  // Phase counter counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [PHASE_CNT_W-1:0] phase_load(input int cycles);
    return PHASE_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sr_latch_write_arbiter_if.sv
// Requester-side handshake bus of the SR latch write arbiter: two requesters,
// each with valid/idx/value and a combinational ready back from the arbiter.
interface sr_latch_write_arbiter_if #(
  parameter int IDX_W = 3
);
  logic             req0_valid;
  logic [IDX_W-1:0] req0_idx;
  logic             req0_value;
  logic             req0_ready;
  logic             req1_valid;
  logic [IDX_W-1:0] req1_idx;
  logic             req1_value;
  logic             req1_ready;

  modport master (
    output req0_valid, req0_idx, req0_value,
    output req1_valid, req1_idx, req1_value,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_idx, req0_value,
    input  req1_valid, req1_idx, req1_value,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/sr_latch_write_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// requester not granted last wins. The favour pointer moves only on accept.
module rr_arbiter_2
  import sr_latch_write_arbiter_pkg::*;
(
  input  logic    clock,
  input  logic    notreset,
  input  logic    valid0,
  input  logic    valid1,
  input  logic    accept,
  output logic    win0,
  output logic    win1,
  output req_id_t grant
);

  req_id_t favour_reg;

  always_comb begin
    grant = 1'b0;
    if (valid0 && valid1) begin
      grant = favour_reg;
    end else if (valid1) begin
      grant = 1'b1;
    end
  end

  assign win0 = valid0 && (grant == 1'b0);
  assign win1 = valid1 && (grant == 1'b1);

  always_ff @(posedge clock or negedge notreset) begin
    if (!notreset) begin
      favour_reg <= 1'b0;
    end else if (accept) begin
      favour_reg <= ~grant;
    end
  end

endmodule

// File: rtl/sr_latch_write_arbiter.sv
// Shares one bank of gated SR latches between two requesters: setup/pulse/hold
// write sequence per accept. Optional readback check: SR_LATCH_READBACK_CHECK_EN.
module sr_latch_write_arbiter
  import sr_latch_write_arbiter_pkg::*;
#(
  parameter int NUM_LATCH = 8,
  parameter int IDX_W     = 3,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                    clock,
  input  logic                    notreset,
  sr_latch_write_arbiter_if.slave req_bus,
  output logic [NUM_LATCH-1:0]    latch_enable,
  output logic                    latch_set,
  output logic                    latch_reset,
  input  logic [NUM_LATCH-1:0]    latch_out,
  input  logic [NUM_LATCH-1:0]    latch_notout,
  output logic                    busy,
  output req_id_t                 grant_id,
  output logic                    done,
  output logic                    error
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_SETUP = ST_SETUP;
  localparam logic [2:0] S_PULSE = ST_PULSE;
  localparam logic [2:0] S_HOLD  = ST_HOLD;
  localparam logic [2:0] S_CHECK = ST_CHECK;

  localparam logic [PHASE_CNT_W-1:0] SETUP_LOAD = phase_load(SETUP_CYC);
  localparam logic [PHASE_CNT_W-1:0] PULSE_LOAD = phase_load(PULSE_CYC);
  localparam logic [PHASE_CNT_W-1:0] HOLD_LOAD  = phase_load(HOLD_CYC);

  logic [2:0]             state_reg;
  logic [PHASE_CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic                   value_reg;
  req_id_t                grant_id_reg;
  logic                   done_reg;
  logic                   error_reg;

  logic    idle;
  logic    accept;
  logic    win0;
  logic    win1;
  req_id_t grant;
  logic    idx_ok;
  logic    cnt_zero;
  logic    drive_phase;

  assign idle     = (state_reg == S_IDLE);
  assign accept   = idle && (req_bus.req0_valid || req_bus.req1_valid);
  assign cnt_zero = (cnt_reg == '0);
  assign idx_ok   = ({1'b0, idx_reg} < (IDX_W + 1)'(NUM_LATCH));

  rr_arbiter_2 u_rr_arbiter_2 (
    .clock    (clock),
    .notreset (notreset),
    .valid0   (req_bus.req0_valid),
    .valid1   (req_bus.req1_valid),
    .accept   (accept),
    .win0     (win0),
    .win1     (win1),
    .grant    (grant)
  );

  assign req_bus.req0_ready = idle && win0;
  assign req_bus.req1_ready = idle && win1;

`ifdef SR_LATCH_READBACK_CHECK_EN
  logic [NUM_LATCH-1:0] out_hit;
  logic [NUM_LATCH-1:0] notout_hit;
  logic                 rd_mismatch;

  // Readback mux built as an AND-OR so an out-of-range index selects nothing.
  for (genvar gi = 0; gi < NUM_LATCH; gi++) begin : g_readback
    assign out_hit[gi]    = latch_out[gi]    && (idx_reg == IDX_W'(gi));
    assign notout_hit[gi] = latch_notout[gi] && (idx_reg == IDX_W'(gi));
  end

  assign rd_mismatch = ((|out_hit) != value_reg) || ((|notout_hit) != ~value_reg);
`else
  logic unused_readback;
  assign unused_readback = ^{latch_out, latch_notout};
`endif

  always_ff @(posedge clock or negedge notreset) begin
    if (!notreset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      value_reg    <= 1'b0;
      grant_id_reg <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            state_reg    <= S_SETUP;
            cnt_reg      <= SETUP_LOAD;
            grant_id_reg <= grant;
            idx_reg      <= grant ? req_bus.req1_idx   : req_bus.req0_idx;
            value_reg    <= grant ? req_bus.req1_value : req_bus.req0_value;
          end
        end
        S_SETUP: begin
          if (cnt_zero) begin
            state_reg <= S_PULSE;
            cnt_reg   <= PULSE_LOAD;
          end else begin
            cnt_reg <= cnt_reg - PHASE_CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_zero) begin
            state_reg <= S_HOLD;
            cnt_reg   <= HOLD_LOAD;
          end else begin
            cnt_reg <= cnt_reg - PHASE_CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
`ifdef SR_LATCH_READBACK_CHECK_EN
            state_reg <= S_CHECK;
`else
            state_reg <= S_IDLE;
            done_reg  <= 1'b1;
            error_reg <= ~idx_ok;
`endif
          end else begin
            cnt_reg <= cnt_reg - PHASE_CNT_W'(1);
          end
        end
        S_CHECK: begin
          state_reg <= S_IDLE;
          done_reg  <= 1'b1;
`ifdef SR_LATCH_READBACK_CHECK_EN
          error_reg <= ~idx_ok || rd_mismatch;
`else
          error_reg <= ~idx_ok;
`endif
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from async-reset state, so reset kills them at once.
  assign drive_phase = (state_reg == S_SETUP) || (state_reg == S_PULSE) ||
                       (state_reg == S_HOLD);
  assign latch_set   = drive_phase &&  value_reg;
  assign latch_reset = drive_phase && !value_reg;

  for (genvar gi = 0; gi < NUM_LATCH; gi++) begin : g_enable
    assign latch_enable[gi] = (state_reg == S_PULSE) && (idx_reg == IDX_W'(gi));
  end

  assign busy     = !idle;
  assign grant_id = grant_id_reg;
  assign done     = done_reg;
  assign error    = error_reg;

endmodule

// File: tb/tb_sr_latch_write_arbiter.sv
// Self-checking bench for sr_latch_write_arbiter with a behavioural latch bank,
// a cycle-level timeline model and directed literal checks.
module tb_sr_latch_write_arbiter;

  localparam int NL = 8;
  localparam int IW = 4;
  localparam int S  = 1;
  localparam int P  = 2;
  localparam int H  = 1;
`ifdef SR_LATCH_READBACK_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int LAT = S + P + H + CHK;

  logic clock = 1'b0;
  logic notreset = 1'b0;
  always #5 clock = ~clock;

  sr_latch_write_arbiter_if #(.IDX_W(IW)) bus ();

  logic [NL-1:0] latch_enable;
  logic [NL-1:0] latch_out;
  logic [NL-1:0] latch_notout;
  logic          latch_set;
  logic          latch_reset;
  logic          busy;
  logic          grant_id;
  logic          done;
  logic          error;

  sr_latch_write_arbiter #(
    .NUM_LATCH (NL),
    .IDX_W     (IW),
    .SETUP_CYC (S),
    .PULSE_CYC (P),
    .HOLD_CYC  (H)
  ) dut (
    .clock        (clock),
    .notreset     (notreset),
    .req_bus      (bus.slave),
    .latch_enable (latch_enable),
    .latch_set    (latch_set),
    .latch_reset  (latch_reset),
    .latch_out    (latch_out),
    .latch_notout (latch_notout),
    .busy         (busy),
    .grant_id     (grant_id),
    .done         (done),
    .error        (error)
  );

  // Gated SR latch bank; stuck0 forces a latch output low.
  logic [NL-1:0] q = '0;
  logic [NL-1:0] stuck0 = '0;
  always @(latch_enable or latch_set or latch_reset) begin
    for (int i = 0; i < NL; i++) begin
      if (latch_enable[i]) begin
        if (latch_set) q[i] = 1'b1;
        else if (latch_reset) q[i] = 1'b0;
      end
    end
  end
  assign latch_out    = q & ~stuck0;
  assign latch_notout = ~latch_out;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Timeline model: an accepted op is busy for LAT cycles, then done/error.
  bit m_active = 0;
  int m_t = 0;
  int m_idx = 0;
  bit m_val = 0;
  bit m_gid = 0;
  bit m_fav = 0;
  bit m_done = 0;
  bit m_err = 0;

  int acc_edge[$];
  bit acc_gid[$];
  int done_cnt = 0;
  int done_edge = 0;
  bit done_err = 0;
  int en_cycles[NL];
  int set_cycles = 0;

  always @(negedge clock) begin
    logic [NL-1:0] e_en;
    logic e_set, e_rst, e_busy, e_r0, e_r1, e_done, e_err;
    bit win1;
    if (!notreset) begin
      m_active = 0; m_done = 0; m_err = 0; m_gid = 0; m_fav = 0;
    end
    e_en = '0; e_set = 0; e_rst = 0; e_busy = 0; e_r0 = 0; e_r1 = 0;
    e_done = 0; e_err = 0; win1 = 0;
    if (m_active) begin
      e_busy = 1;
      if (m_t < S + P + H) begin
        e_set = m_val;
        e_rst = !m_val;
      end
      if (m_t >= S && m_t < S + P && m_idx < NL) e_en[m_idx] = 1'b1;
    end else begin
      e_done = m_done;
      e_err  = m_err;
      if (bus.req0_valid && bus.req1_valid) win1 = m_fav;
      else win1 = bus.req1_valid;
      e_r0 = bus.req0_valid && !win1;
      e_r1 = bus.req1_valid && win1;
    end
    check("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
    check("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
    check("latch_enable", 32'(latch_enable), 32'(e_en));
    check("latch_set", 32'(latch_set), 32'(e_set));
    check("latch_reset", 32'(latch_reset), 32'(e_rst));
    check("busy", 32'(busy), 32'(e_busy));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    check("done", 32'(done), 32'(e_done));
    check("error", 32'(error), 32'(e_err));
    check("set_and_reset", 32'(latch_set & latch_reset), 32'd0);
    check("enable_onehot0", 32'($onehot0(latch_enable)), 32'd1);

    if (done) begin
      done_cnt++;
      done_edge = cyc;
      done_err  = error;
    end
    for (int i = 0; i < NL; i++) if (latch_enable[i]) en_cycles[i]++;
    if (latch_set) set_cycles++;
    if (bus.req0_ready || bus.req1_ready) begin
      acc_edge.push_back(cyc + 1);
      acc_gid.push_back(bus.req1_ready);
    end

    if (m_active) begin
      m_t++;
      if (m_t == LAT) begin
        m_active = 0;
        m_done = 1;
        m_err = 1;
        if (m_idx < NL) m_err = (CHK == 1) && m_val && stuck0[m_idx];
      end
    end else begin
      m_done = 0;
      m_err = 0;
      if (e_r0 || e_r1) begin
        m_active = 1;
        m_t = 0;
        m_gid = e_r1;
        m_fav = !e_r1;
        m_idx = e_r1 ? int'(bus.req1_idx) : int'(bus.req0_idx);
        m_val = e_r1 ? bus.req1_value : bus.req0_value;
      end
    end
  end

  task automatic wait_accepts(input int n);
    int k;
    for (k = 0; k < 40 && acc_edge.size() < n; k++) begin
      @(negedge clock);
      #1;
    end
    check("accept_timeout", 32'(acc_edge.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int dc);
    int k;
    for (k = 0; k < 40 && done_cnt == dc; k++) begin
      @(negedge clock);
      #1;
    end
    check("done_timeout", 32'(done_cnt > dc), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #2 notreset = 1'b0;
    @(posedge clock);
    #2 notreset = 1'b1;
  endtask

  // One write from a single requester; returns after done.
  task automatic single_write(input int r, input logic [IW-1:0] idx, input logic val);
    int n;
    int dc;
    n = acc_edge.size();
    dc = done_cnt;
    @(posedge clock);
    #1;
    if (r == 0) begin
      bus.req0_valid = 1'b1; bus.req0_idx = idx; bus.req0_value = val;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_idx = idx; bus.req1_value = val;
    end
    wait_accepts(n + 1);
    @(posedge clock);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_done(dc);
    if (acc_edge.size() > n) begin
      check("latency", 32'(done_edge - acc_edge[n]), 32'(LAT));
      check("grant_literal", 32'(acc_gid[n]), 32'(r));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc;
    int tot;
    bus.req0_valid = 0; bus.req0_idx = '0; bus.req0_value = 0;
    bus.req1_valid = 0; bus.req1_idx = '0; bus.req1_value = 0;
    for (int i = 0; i < NL; i++) en_cycles[i] = 0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_enable", 32'(latch_enable), 32'd0);
    check("rst_done", 32'(done | error), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    repeat (2) @(posedge clock);
    #2 notreset = 1'b1;

    // Write idx3=1 from requester 0.
    set_cycles = 0;
    single_write(0, 4'd3, 1'b1);
    $display("txn write req0 idx=3 val=1 done_err=%0d", done_err);
    check("t1_error", 32'(done_err), 32'd0);
    check("t1_en3_cycles", 32'(en_cycles[3]), 32'd2);
    check("t1_set_cycles", 32'(set_cycles), 32'd4);
    check("t1_q3", 32'(q[3]), 32'd1);

    // Both requesters held valid: grants alternate 0,1,0.
    pulse_reset();
    n = acc_edge.size();
    @(posedge clock);
    #1;
    bus.req0_valid = 1; bus.req0_idx = 4'd1; bus.req0_value = 0;
    bus.req1_valid = 1; bus.req1_idx = 4'd2; bus.req1_value = 1;
    wait_accepts(n + 3);
    @(posedge clock);
    #1;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    repeat (LAT + 2) @(posedge clock);
    if (acc_edge.size() >= n + 3) begin
      $display("txn rr grants=%0d,%0d,%0d", acc_gid[n], acc_gid[n+1], acc_gid[n+2]);
      check("rr_grant0", 32'(acc_gid[n]), 32'd0);
      check("rr_grant1", 32'(acc_gid[n+1]), 32'd1);
      check("rr_grant2", 32'(acc_gid[n+2]), 32'd0);
      check("rr_period01", 32'(acc_edge[n+1] - acc_edge[n]), 32'(LAT + 1));
      check("rr_period12", 32'(acc_edge[n+2] - acc_edge[n+1]), 32'(LAT + 1));
    end
    check("rr_q1", 32'(q[1]), 32'd0);
    check("rr_q2", 32'(q[2]), 32'd1);

    // Stuck-at-0 latch 5, write 1.
    stuck0[5] = 1'b1;
    single_write(1, 4'd5, 1'b1);
    $display("txn stuck write req1 idx=5 val=1 done_err=%0d", done_err);
    check("stuck_error", 32'(done_err), 32'(CHK));
    stuck0[5] = 1'b0;

    // Out-of-range index.
    for (int i = 0; i < NL; i++) en_cycles[i] = 0;
    single_write(0, 4'd9, 1'b1);
    tot = 0;
    for (int i = 0; i < NL; i++) tot += en_cycles[i];
    $display("txn write req0 idx=9 val=1 done_err=%0d en_cycles=%0d", done_err, tot);
    check("oor_enable_cycles", 32'(tot), 32'd0);
    check("oor_error", 32'(done_err), 32'd1);

    // Reset during PULSE.
    n = acc_edge.size();
    @(posedge clock);
    #1;
    bus.req0_valid = 1; bus.req0_idx = 4'd2; bus.req0_value = 0;
    wait_accepts(n + 1);
    @(posedge clock);
    #1;
    bus.req0_valid = 0;
    @(posedge clock);
    #2;
    check("pulse_before_reset", 32'(latch_enable[2]), 32'd1);
    dc = done_cnt;
    notreset = 1'b0;
    #1;
    check("async_enable", 32'(latch_enable), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #2 notreset = 1'b1;
    repeat (8) @(posedge clock);
    check("no_done_after_reset", 32'(done_cnt), 32'(dc));
    $display("txn reset during pulse, done_cnt=%0d", done_cnt);

    // Next request after reset: req0 favoured on a tie.
    n = acc_edge.size();
    dc = done_cnt;
    @(posedge clock);
    #1;
    bus.req0_valid = 1; bus.req0_idx = 4'd4; bus.req0_value = 1;
    bus.req1_valid = 1; bus.req1_idx = 4'd6; bus.req1_value = 1;
    wait_accepts(n + 1);
    @(posedge clock);
    #1;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    wait_done(dc);
    if (acc_edge.size() > n) check("post_reset_grant", 32'(acc_gid[n]), 32'd0);
    check("post_reset_error", 32'(done_err), 32'd0);
    check("post_reset_q4", 32'(q[4]), 32'd1);
    $display("txn post-reset tie write idx=4 val=1 done_err=%0d", done_err);

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
